// File: rtl/fwd_pkg.sv
// Shared encodings and the in-flight tag record for the forwarding unit.
package fwd_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_IMM = 2'b01,
        WB_PC4 = 2'b10,
        WB_MEM = 2'b11
    } wb_src_e;

    typedef enum logic [1:0] {
        FWD_REG      = 2'b00,
        FWD_BYPASS   = 2'b01,
        FWD_OVERRIDE = 2'b10
    } fwd_src_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        wb_src_e    wb_src;
    } tag_t;

endpackage

// File: rtl/fwd_operand_match.sv
// Youngest-producer search and readiness test for one source operand.
module fwd_operand_match
    import fwd_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SW       = 2
) (
    input  tag_t [DEPTH-1:0] tags,
    input  logic [4:0]       rs,
    input  logic             used,
    input  logic             override_op,
    output logic             hit,
    output logic [SW-1:0]    stage,
    output logic [1:0]       kind,
    output logic             hazard
);

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit    = 1'b0;
        stage  = '0;
        kind   = 2'b00;
        hazard = 1'b0;
        if (used && !override_op && rs != 5'd0) begin
            for (int p = DEPTH - 1; p >= 0; p--) begin
                if (tags[p].valid && tags[p].rd == rs) begin
                    hit    = 1'b1;
                    stage  = SW'(p + 1);
                    kind   = tags[p].wb_src;
                    hazard = (p + 1) < ((tags[p].wb_src == WB_MEM) ? (LOAD_LAT + 1) : 1);
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and hazard unit: shadows in-flight destination tags and registers
// per-operand bypass selects for the instruction entering EX.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                id_valid,
    input  logic [NUM_SRC*5-1:0]                id_rs,
    input  logic [NUM_SRC-1:0]                  id_rs_used,
    input  logic [NUM_SRC-1:0]                  id_override,
    input  logic [4:0]                          id_rd,
    input  logic                                id_reg_write,
    input  logic [1:0]                          id_wb_src,
    input  logic                                flush,
    output logic                                stall,
    output logic [NUM_SRC*2-1:0]                fwd_src,
    output logic [NUM_SRC*$clog2(DEPTH+1)-1:0]  fwd_stage,
    output logic [NUM_SRC*2-1:0]                fwd_kind,
    output logic [CNT_W-1:0]                    stall_count
);

    localparam int SW = $clog2(DEPTH + 1);

    tag_t [DEPTH-1:0]     tags;
    tag_t                 new_tag;
    logic                 issue;
    logic [NUM_SRC-1:0]   hit;
    logic [NUM_SRC-1:0]   hazard;
    logic [NUM_SRC*SW-1:0] hit_stage;
    logic [NUM_SRC*2-1:0] hit_kind;
    logic [NUM_SRC*2-1:0] src_nxt;
    logic [NUM_SRC*SW-1:0] stage_nxt;
    logic [NUM_SRC*2-1:0] kind_nxt;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
        fwd_operand_match #(
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .SW       (SW)
        ) u_match (
            .tags        (tags),
            .rs          (id_rs[5*i +: 5]),
            .used        (id_rs_used[i]),
            .override_op (id_override[i]),
            .hit         (hit[i]),
            .stage       (hit_stage[SW*i +: SW]),
            .kind        (hit_kind[2*i +: 2]),
            .hazard      (hazard[i])
        );
    end

    // flush outranks a hazard: the killed instruction must not hold the front end.
    assign stall = id_valid && !flush && (|hazard);
    assign issue = id_valid && !stall && !flush;

    always_comb begin
        new_tag = '0;
        if (issue) begin
            new_tag.valid  = id_reg_write && (id_rd != 5'd0);
            new_tag.rd     = id_rd;
            new_tag.wb_src = wb_src_e'(id_wb_src);
        end
    end

    always_comb begin
        src_nxt   = '0;
        stage_nxt = '0;
        kind_nxt  = '0;
        if (issue) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (id_override[i]) begin
                    src_nxt[2*i +: 2] = FWD_OVERRIDE;
                end else if (hit[i]) begin
                    src_nxt[2*i +: 2]    = FWD_BYPASS;
                    stage_nxt[SW*i +: SW] = hit_stage[SW*i +: SW];
                    kind_nxt[2*i +: 2]   = hit_kind[2*i +: 2];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tags        <= '0;
            fwd_src     <= '0;
            fwd_stage   <= '0;
            fwd_kind    <= '0;
            stall_count <= '0;
        end else begin
            tags      <= {tags[DEPTH-2:0], new_tag};
            fwd_src   <= src_nxt;
            fwd_stage <= stage_nxt;
            fwd_kind  <= kind_nxt;
            if (stall && stall_count != {CNT_W{1'b1}}) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed-vector bench; expected selects are queued per issue cycle and
// checked by an independent monitor one edge later.
module tb_fwd_scoreboard;

    localparam int NUM_SRC  = 2;
    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 1;
    localparam int CNT_W    = 2;
    localparam int SW       = $clog2(DEPTH + 1);

    typedef struct {
        logic [3:0]       src;
        logic [3:0]       stage;
        logic [3:0]       kind;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic                  id_valid;
    logic [NUM_SRC*5-1:0]  id_rs;
    logic [NUM_SRC-1:0]    id_rs_used;
    logic [NUM_SRC-1:0]    id_override;
    logic [4:0]            id_rd;
    logic                  id_reg_write;
    logic [1:0]            id_wb_src;
    logic                  flush;
    logic                  stall;
    logic [NUM_SRC*2-1:0]  fwd_src;
    logic [NUM_SRC*SW-1:0] fwd_stage;
    logic [NUM_SRC*2-1:0]  fwd_kind;
    logic [CNT_W-1:0]      stall_count;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    fwd_scoreboard #(
        .NUM_SRC  (NUM_SRC),
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rs_used   (id_rs_used),
        .id_override  (id_override),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_wb_src    (id_wb_src),
        .flush        (flush),
        .stall        (stall),
        .fwd_src      (fwd_src),
        .fwd_stage    (fwd_stage),
        .fwd_kind     (fwd_kind),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive one ID cycle at the falling edge, check the combinational stall,
    // and queue the selects expected after the next rising edge.
    task automatic step(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [1:0] used, input logic [1:0] ovr,
                        input logic [4:0] rd, input logic rw, input logic [1:0] wb,
                        input logic fl, input logic e_stall,
                        input logic [3:0] e_src, input logic [3:0] e_stage,
                        input logic [3:0] e_kind, input logic [CNT_W-1:0] e_cnt);
        exp_t e;
        @(negedge clk);
        id_valid     = v;
        id_rs        = {rs1, rs0};
        id_rs_used   = used;
        id_override  = ovr;
        id_rd        = rd;
        id_reg_write = rw;
        id_wb_src    = wb;
        flush        = fl;
        #1;
        check("stall", 32'(stall), 32'(e_stall));
        e.src   = e_src;
        e.stage = e_stage;
        e.kind  = e_kind;
        e.cnt   = e_cnt;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("fwd_src",     32'(fwd_src),     32'(e.src));
            check("fwd_stage",   32'(fwd_stage),   32'(e.stage));
            check("fwd_kind",    32'(fwd_kind),    32'(e.kind));
            check("stall_count", 32'(stall_count), 32'(e.cnt));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        id_valid = 1'b0; id_rs = '0; id_rs_used = '0; id_override = '0;
        id_rd = '0; id_reg_write = 1'b0; id_wb_src = '0; flush = 1'b0;
        #2;
        check("rst_stall",     32'(stall),       32'd0);
        check("rst_fwd_src",   32'(fwd_src),     32'd0);
        check("rst_fwd_stage", 32'(fwd_stage),   32'd0);
        check("rst_fwd_kind",  32'(fwd_kind),    32'd0);
        check("rst_count",     32'(stall_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //    v  rs0 rs1 used   ovr    rd rw wb fl | st src     stage   kind    cnt
        step(1,  0,  0, 2'b00, 2'b00, 5, 1, 0, 0,  0, 4'b0000, 4'b0000, 4'b0000, 0); // ALU x5
        step(1,  5,  0, 2'b01, 2'b00, 6, 0, 0, 0,  0, 4'b0001, 4'b0001, 4'b0000, 0); // use x5
        step(1,  0,  0, 2'b00, 2'b00, 7, 1, 3, 0,  0, 4'b0000, 4'b0000, 4'b0000, 0); // load x7
        step(1,  0,  7, 2'b10, 2'b00, 0, 0, 0, 0,  1, 4'b0000, 4'b0000, 4'b0000, 1); // load-use
        step(1,  0,  7, 2'b10, 2'b00, 0, 0, 0, 0,  0, 4'b0100, 4'b1000, 4'b1100, 1);
        step(1,  0,  0, 2'b00, 2'b00, 3, 1, 1, 0,  0, 4'b0000, 4'b0000, 4'b0000, 1); // x3 IMM
        step(1,  0,  0, 2'b00, 2'b00, 3, 1, 2, 0,  0, 4'b0000, 4'b0000, 4'b0000, 1); // x3 PC4
        step(1,  3,  3, 2'b11, 2'b00, 0, 0, 0, 0,  0, 4'b0101, 4'b0101, 4'b1010, 1); // youngest
        step(1,  3,  3, 2'b11, 2'b10, 0, 0, 0, 0,  0, 4'b1001, 4'b0010, 4'b0010, 1); // override
        step(1,  3,  3, 2'b01, 2'b00, 0, 0, 0, 0,  0, 4'b0001, 4'b0011, 4'b0010, 1); // stage 3
        step(1,  0,  0, 2'b00, 2'b00, 0, 1, 3, 0,  0, 4'b0000, 4'b0000, 4'b0000, 1); // load x0
        step(1,  0,  0, 2'b11, 2'b00, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 4'b0000, 1);
        step(1,  0,  0, 2'b00, 2'b00, 9, 1, 3, 0,  0, 4'b0000, 4'b0000, 4'b0000, 1); // load x9
        step(1,  9,  0, 2'b01, 2'b00, 0, 0, 0, 1,  0, 4'b0000, 4'b0000, 4'b0000, 1); // flush wins
        step(1,  9,  0, 2'b01, 2'b00, 0, 0, 0, 0,  0, 4'b0001, 4'b0010, 4'b0011, 1);
        step(1,  0,  0, 2'b00, 2'b00, 10, 1, 3, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1); // load x10
        step(0, 10,  0, 2'b01, 2'b00, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 4'b0000, 1); // not valid
        step(1,  0,  0, 2'b00, 2'b00, 11, 1, 3, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1); // load x11
        step(1, 11,  0, 2'b01, 2'b00, 0, 0, 0, 0,  1, 4'b0000, 4'b0000, 4'b0000, 2);
        step(1, 11,  0, 2'b01, 2'b00, 12, 1, 3, 0, 0, 4'b0001, 4'b0010, 4'b0011, 2);
        step(1, 12,  0, 2'b01, 2'b00, 0, 0, 0, 0,  1, 4'b0000, 4'b0000, 4'b0000, 3);
        step(1, 12,  0, 2'b01, 2'b00, 13, 1, 3, 0, 0, 4'b0001, 4'b0010, 4'b0011, 3);
        step(1, 13,  0, 2'b01, 2'b00, 0, 0, 0, 0,  1, 4'b0000, 4'b0000, 4'b0000, 3); // saturate
        step(1, 13,  0, 2'b01, 2'b00, 14, 1, 3, 0, 0, 4'b0001, 4'b0010, 4'b0011, 3);

        // Reset while the load-use on x14 is stalling.
        @(negedge clk);
        id_valid = 1'b1; id_rs = {5'd0, 5'd14}; id_rs_used = 2'b01; id_override = 2'b00;
        id_rd = 5'd0; id_reg_write = 1'b0; id_wb_src = 2'b00; flush = 1'b0;
        #1;
        check("pre_rst_stall", 32'(stall), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_stall",     32'(stall),       32'd0);
        check("mid_rst_fwd_src",   32'(fwd_src),     32'd0);
        check("mid_rst_fwd_stage", 32'(fwd_stage),   32'd0);
        check("mid_rst_fwd_kind",  32'(fwd_kind),    32'd0);
        check("mid_rst_count",     32'(stall_count), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        step(1, 14,  0, 2'b01, 2'b00, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 4'b0000, 0);
        step(1,  0,  0, 2'b00, 2'b00, 5, 1, 0, 0,  0, 4'b0000, 4'b0000, 4'b0000, 0);
        step(1,  0,  5, 2'b10, 2'b00, 0, 0, 0, 0,  0, 4'b0100, 4'b0100, 4'b0000, 0);

        @(negedge clk);
        id_valid = 1'b0;
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and hazard unit for the pipelined core. It sits between ID and EX and keeps its own shift register of in-flight destination tags, so it does not depend on the pipeline registers for them. Each cycle it resolves NUM_SRC source operands of the ID instruction against every younger producer and registers per-operand bypass selects aligned to EX. It detects load-use and multi-cycle-load hazards and raises a stall. The pipeline depth, operand count and load latency are parameters.

## Interface
- NUM_SRC, 2, source operands per instruction
- DEPTH, 3, in-flight tag positions tracked (EX, MEM, WB, ...); must be at least LOAD_LAT+1
- LOAD_LAT, 1, extra cycles after EX before load data is forwardable
- CNT_W, 32, stall counter width

- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  NUM_SRC*5  source register numbers; operand i is bits [5i+4:5i]
- id_rs_used  in  NUM_SRC  operand i reads the register file
- id_override  in  NUM_SRC  operand i takes PC/imm instead of a register (auipc, alu_src_b)
- id_rd  in  5  destination register
- id_reg_write  in  1  instruction writes rd
- id_wb_src  in  2  producer result kind: ALU, IMM, PC4 or MEM
- flush  in  1  kill the ID instruction (branch/jump resolved)
- stall  out  1  hold IF/ID and insert a bubble into EX; combinational
- fwd_src  out  NUM_SRC*2  per operand: REG, BYPASS or OVERRIDE; registered
- fwd_stage  out  NUM_SRC*$clog2(DEPTH+1)  pipeline register to bypass from (1 = EX/MEM); registered
- fwd_kind  out  NUM_SRC*2  wb_src of the selected producer; registered
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Tag array: positions 0..DEPTH-1. Each entry holds {valid, rd, wb_src}. Position 0 is the instruction in EX.
- Each cycle, every tag shifts p to p+1. The entry at DEPTH-1 is retired; its value is read from the register file, which is write-first.
- Issue: id_valid && !stall && !flush. A tag is loaded into position 0 with valid = id_reg_write && id_rd != 0. In every other case a bubble (valid=0) is loaded.
- Operand i match: the youngest valid tag p with rd == rs_i, considered only when id_rs_used[i] && !id_override[i].
- Ready position: 1 for ALU, IMM and PC4 producers; 1+LOAD_LAT for MEM producers.
- Hazard: the matched tag satisfies p+1 < ready position. stall is the OR of all operand hazards, gated by id_valid and !flush.
- Registered selects, loaded on issue:
  - id_override[i] gives OVERRIDE.
  - A match gives BYPASS with fwd_stage = p+1 and fwd_kind = the tag's wb_src.
  - Otherwise REG.
- On stall or flush, all selects load REG, stage 0 and kind 0, which is a bubble in EX.
- Only the youngest match is used; older tags with the same rd are ignored. Register x0 never matches.
- stall_count increments on each stall cycle and saturates at all-ones.

## Timing
- Reset (asynchronous): all tags invalid; fwd_src=REG, fwd_stage=0, fwd_kind=0, stall_count=0. stall reads 0 because every tag is invalid.
- Select latency: one cycle. Selects computed in cycle t are valid throughout the consumer's EX cycle t+1.
- A MEM producer stalls a dependent instruction directly behind it for LOAD_LAT cycles; at LOAD_LAT=1 this is one cycle.
- flush together with a stall condition: flush wins. stall=0, a bubble is issued and stall_count is unchanged.
- Reset asserted mid-stall: all state clears immediately; the first cycle after release issues normally.

## Structure
- Shared package fwd_pkg holds:
  - wb_src encodings: ALU=2'b00, IMM=2'b01, PC4=2'b10, MEM=2'b11.
  - fwd_src encodings: REG=2'b00, BYPASS=2'b01, OVERRIDE=2'b10.
  - The tag struct.
- One sub-module, fwd_operand_match. It is instantiated NUM_SRC times and does the youngest-match priority search and hazard test for one operand.

## Test plan
- Back-to-back ALU writes x5 and the next instruction reads x5 → no stall; fwd_src=BYPASS, fwd_stage=1, fwd_kind=ALU in the consumer's EX.
- Load to x7, then an immediate use of x7 (LOAD_LAT=1) → stall=1 for one cycle, stall_count=1, then BYPASS with stage=2 and kind=MEM.
- Two writers to x3 at positions 0 and 1, then a read of x3 → stage=1 (youngest producer wins).
- Write to x0, then a read of x0 → REG, no stall. id_override[0]=1 with a matching rs → OVERRIDE.
- Load-use condition with flush=1 in the same cycle → stall=0, bubble issued, selects=REG, stall_count unchanged.
- Assert rst while a stall is pending → all outputs return to reset values asynchronously; normal issue resumes on release.
